// File: rtl/jtpang_dial_acc.sv
// jtpang_dial_acc: per-player dial/trackball position accumulators with a latched CPU read port.
module jtpang_dial_acc #(
  parameter int CH = 2,
  parameter int MW = 8,
  parameter int DW = 8,
  parameter int SHIFT = 0,
  parameter bit WRAP = 1'b1,
  parameter logic [CH-1:0] INVERT = '0
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [CH-1:0]    mouse_st,
  input  logic [CH*MW-1:0] mouse_dx,
  input  logic [CH-1:0]    clr,
  input  logic [1:0]       sel,
  input  logic             rd,
  output logic [DW-1:0]    dout,
  output logic [CH-1:0]    moved
);
  localparam int AW = DW + SHIFT;
  // Wide enough that no accumulator + delta (including a negated most-negative delta) overflows
  localparam int XW = (AW > MW ? AW : MW) + 2;
  logic [AW-1:0] r_acc [CH];
  logic [AW-1:0] w_nxt [CH];
  logic [DW-1:0] w_vis [CH];
  logic [CH-1:0] w_chg, w_rdc, r_moved;
  logic [DW-1:0] w_rd, r_dout;
  logic [1:0]    w_sel;
  assign w_sel = 32'(sel) < CH ? sel : 2'd0;
  assign dout  = r_dout;
  assign moved = r_moved;
  genvar n;
  for (n = 0; n < CH; n++) begin : g_ch
    logic [MW-1:0]        w_dx;
    logic [XW-1:0]        w_ext;
    logic signed [XW-1:0] w_d, w_sum;
    assign w_dx   = mouse_dx[n*MW +: MW];
    assign w_ext  = {{(XW-MW){w_dx[MW-1]}}, w_dx};
    assign w_d    = INVERT[n] ? -w_ext : w_ext;
    assign w_sum  = {{(XW-AW){1'b0}}, r_acc[n]} + w_d;
    assign w_nxt[n] = clr[n] ? '0 :
                      !mouse_st[n] ? r_acc[n] :
                      WRAP ? w_sum[AW-1:0] :
                      w_sum[XW-1] ? '0 :
                      |w_sum[XW-2:AW] ? '1 : w_sum[AW-1:0];
    assign w_vis[n] = r_acc[n][AW-1 -: DW];
    assign w_chg[n] = w_nxt[n][AW-1 -: DW] != w_vis[n];
    assign w_rdc[n] = rd && w_sel == 2'(n);
  end
  always_comb begin
    w_rd = w_vis[0];
    for (int i = 1; i < CH; i++) w_rd = w_sel == 2'(i) ? w_vis[i] : w_rd;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout  <= '0;
      r_moved <= '0;
      for (int i = 0; i < CH; i++) r_acc[i] <= '0;
    end else begin
      if (rd) r_dout <= w_rd;
      for (int i = 0; i < CH; i++) begin
        r_acc[i]   <= w_nxt[i];
        // a visible change wins over the read-clear; clear wins over both
        r_moved[i] <= !clr[i] && (w_chg[i] || (r_moved[i] && !w_rdc[i]));
      end
    end
  end
endmodule

// File: tb/tb_jtpang_dial_acc.sv
// tb_jtpang_dial_acc: two differently configured accumulators driven in parallel and checked
// against an integer position model every cycle, plus hand-computed spot values.
module tb_jtpang_dial_acc;
  logic        clk, rst;
  logic [2:0]  st, clr_i;
  logic [23:0] dx;
  logic [1:0]  sel;
  logic        rd;
  logic [7:0]  dout_a, dout_b;
  logic [1:0]  moved_a;
  logic [2:0]  moved_b;
  int checks = 0, errors = 0;
  int m_acc [2][3];
  int m_dout [2];
  bit m_moved [2][3];
  int c_ch [2]   = '{2, 3};
  int c_sh [2]   = '{0, 2};
  int c_wrap [2] = '{1, 0};
  int c_inv [2]  = '{2, 1};

  jtpang_dial_acc #(.CH(2), .MW(8), .DW(8), .SHIFT(0), .WRAP(1'b1), .INVERT(2'b10)) u_a (
    .clk(clk), .rst(rst), .mouse_st(st[1:0]), .mouse_dx(dx[15:0]), .clr(clr_i[1:0]),
    .sel(sel), .rd(rd), .dout(dout_a), .moved(moved_a));
  jtpang_dial_acc #(.CH(3), .MW(8), .DW(8), .SHIFT(2), .WRAP(1'b0), .INVERT(3'b001)) u_b (
    .clk(clk), .rst(rst), .mouse_st(st), .mouse_dx(dx), .clr(clr_i),
    .sel(sel), .rd(rd), .dout(dout_b), .moved(moved_b));

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int exp_moved(int k);
    int e = 0;
    for (int n = 0; n < c_ch[k]; n++) e |= int'(m_moved[k][n]) << n;
    return e;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_dout[k] = 0;
      for (int n = 0; n < 3; n++) begin m_acc[k][n] = 0; m_moved[k][n] = 0; end
    end
  endfunction

  function automatic void model_edge();
    for (int k = 0; k < 2; k++) begin
      int top = 1 << (8 + c_sh[k]);
      int s = int'(sel) < c_ch[k] ? int'(sel) : 0;
      int ov [3];
      for (int n = 0; n < c_ch[k]; n++) ov[n] = m_acc[k][n] >> c_sh[k];
      if (rd) begin m_dout[k] = ov[s]; m_moved[k][s] = 0; end
      for (int n = 0; n < c_ch[k]; n++) begin
        if (clr_i[n]) m_acc[k][n] = 0;
        else if (st[n]) begin
          int d = int'($signed(dx[n*8 +: 8]));
          int t;
          if ((c_inv[k] >> n) & 1) d = -d;
          t = m_acc[k][n] + d;
          if (c_wrap[k] != 0) t = ((t % top) + top) % top;
          else t = t < 0 ? 0 : (t > top - 1 ? top - 1 : t);
          m_acc[k][n] = t;
        end
        if (clr_i[n]) m_moved[k][n] = 0;
        else if ((m_acc[k][n] >> c_sh[k]) != ov[n]) m_moved[k][n] = 1;
      end
    end
  endfunction

  always @(negedge clk) begin
    chk("dout_a", int'(dout_a), m_dout[0]);
    chk("moved_a", int'(moved_a), exp_moved(0));
    chk("dout_b", int'(dout_b), m_dout[1]);
    chk("moved_b", int'(moved_b), exp_moved(1));
  end

  function automatic logic [23:0] pack(int a, int b, int c);
    return {c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic cyc(input logic [2:0] s, input logic [23:0] x, input logic [2:0] c,
                     input logic [1:0] sl, input logic r);
    st = s; dx = x; clr_i = c; sel = sl; rd = r;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    rst = 1; st = 0; dx = 0; clr_i = 0; sel = 0; rd = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    cyc(0, 0, 0, 0, 1);
    chk("reset_dout0", int'(dout_a), 0);
    chk("reset_moved", int'(moved_a), 0);
    cyc(0, 0, 0, 1, 1);
    chk("reset_dout1", int'(dout_a), 0);
    chk("reset_moved_b", int'(moved_b), 0);
    // modulo wrap on A channel 0
    cyc(1, pack(100, 0, 0), 0, 0, 0);
    cyc(1, pack(100, 0, 0), 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_200", int'(dout_a), 'hC8);
    cyc(1, pack(100, 0, 0), 0, 0, 0);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_2c", int'(dout_a), 'h2C);
    cyc(1, pack(-50, 0, 0), 0, 0, 0);
    chk("wrap_moved", int'(moved_a[0]), 1);
    cyc(0, 0, 0, 0, 1);
    chk("wrap_fa", int'(dout_a), 'hFA);
    chk("wrap_rdclr", int'(moved_a[0]), 0);
    // saturation on B channel 1 (SHIFT=2: acc ceiling 1023)
    cyc(3'b010, pack(0, -5, 0), 0, 0, 0);
    repeat (9) cyc(3'b010, pack(0, 127, 0), 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("sat_ff", int'(dout_b), 'hFF);
    cyc(3'b010, pack(0, 1, 0), 0, 0, 0);
    chk("sat_nomove", int'(moved_b[1]), 0);
    // fractional sensitivity on B channel 2
    repeat (3) cyc(3'b100, pack(0, 0, 1), 0, 0, 0);
    chk("frac_nomove", int'(moved_b[2]), 0);
    cyc(3'b100, pack(0, 0, 1), 0, 0, 0);
    chk("frac_move", int'(moved_b[2]), 1);
    cyc(0, 0, 0, 2, 1);
    chk("frac_one", int'(dout_b), 1);
    cyc(3'b100, pack(0, 0, -1), 0, 0, 0);
    cyc(0, 0, 0, 2, 1);
    chk("frac_zero", int'(dout_b), 0);
    // same-edge collisions
    cyc(3'b001, pack(3, 0, 0), 0, 0, 1);
    chk("coll_old", int'(dout_a), 'hFA);
    chk("coll_moved", int'(moved_a[0]), 1);
    cyc(3'b010, pack(0, 9, 0), 3'b010, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("clr_wins", int'(dout_a), 0);
    // inverted channel
    cyc(3'b010, pack(0, 4, 0), 0, 0, 0);
    cyc(0, 0, 0, 1, 1);
    chk("invert_fc", int'(dout_a), 'hFC);
    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      logic [23:0] x = 24'($urandom);
      logic [2:0]  c = ($urandom_range(0, 15) == 0) ? 3'($urandom) : 3'b0;
      if ($urandom_range(0, 7) == 0) x[7:0] = 8'h80;
      if ($urandom_range(0, 7) == 0) x[15:8] = 8'h80;
      cyc(3'($urandom), x, c, 2'($urandom), $urandom_range(0, 2) == 0);
    end
    // asynchronous reset between edges, with a strobe pending across the next edge
    st = 3'b111; dx = pack(20, 20, 20); clr_i = 0; rd = 1; sel = 0;
    #2 rst = 1;
    model_reset();
    #1;
    chk("async_dout_a", int'(dout_a), 0);
    chk("async_moved_b", int'(moved_b), 0);
    @(posedge clk);
    #3 rst = 0;
    st = 0; dx = 0; rd = 0;
    for (int s = 0; s < 4; s++) begin
      cyc(0, 0, 0, 2'(s), 1);
      chk("post_rst_a", int'(dout_a), 0);
      chk("post_rst_b", int'(dout_b), 0);
    end
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
